// File: rtl/rib_sram_slave.sv
// rib_sram_slave: RIB bus responder around a word-addressed, byte-maskable
// register memory. One request per handshake (req & gnt); the response is
// raised WAIT_CYCLES+1 cycles later and held until the initiator signals rdy.
// Back-to-back transfers are accepted in RESP when rdy is high.
//
// Ports:
//   i_clk, i_rstn      clock, asynchronous active-low reset
//   i_ribs_addr        byte address, word index in [AW+1:2], other bits alias
//   i_ribs_wrcs        1 = write, 0 = read
//   i_ribs_mask        byte-lane write enables
//   i_ribs_wdata       lane-aligned write data
//   i_ribs_req         request valid
//   o_ribs_gnt         grant (combinational)
//   o_ribs_rsp         response valid
//   o_ribs_rdata       read data (zero for write responses)
//   i_ribs_rdy         initiator accepts the response
//   o_busy             high in WAIT or RESP
module rib_sram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_ribs_addr,
  input  logic        i_ribs_wrcs,
  input  logic [3:0]  i_ribs_mask,
  input  logic [31:0] i_ribs_wdata,
  input  logic        i_ribs_req,
  output logic        o_ribs_gnt,
  output logic        o_ribs_rsp,
  output logic [31:0] o_ribs_rdata,
  input  logic        i_ribs_rdy,
  output logic        o_busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // State entered on a handshake.
  localparam state_e ST_AFTER_HS = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rsp_q, rsp_d;
  logic            busy_q, busy_d;
  logic            gnt_c;
  logic            hs_c;
  logic [AW-1:0]   idx_c;
  logic [31:0]     rd_word_c;
  logic [31:0]     mem [DEPTH];
  logic            unused_addr_bits;

  assign idx_c            = i_ribs_addr[AW+1:2];
  assign unused_addr_bits = ^{i_ribs_addr[31:AW+2], i_ribs_addr[1:0]};
  assign rd_word_c        = mem[idx_c];

  // Grant: open in IDLE, or in RESP when the current response is being taken.
  always_comb begin
    gnt_c = 1'b0;
    case (state_q)
      ST_IDLE: gnt_c = 1'b1;
      ST_RESP: gnt_c = i_ribs_rdy;
      default: gnt_c = 1'b0;
    endcase
    gnt_c = gnt_c & i_rstn;
  end

  assign hs_c = i_ribs_req & gnt_c;

  // Next-state, wait counter and response data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_ribs_rdy) state_d = ST_IDLE;
      end
      default: ;
    endcase
    // A handshake overrides the RESP->IDLE exit to keep back-to-back flow.
    if (hs_c) begin
      state_d = ST_AFTER_HS;
      cnt_d   = CW'(WAIT_CYCLES);
      rdata_d = i_ribs_wrcs ? 32'h0 : rd_word_c;
    end
    rsp_d  = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
  end

  // Control and response registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
      busy_q  <= busy_d;
    end
  end

  // Memory array: byte-lane writes at the handshake edge, never reset.
  always_ff @(posedge i_clk) begin
    if (hs_c && i_ribs_wrcs) begin
      for (int n = 0; n < 4; n++) begin
        if (i_ribs_mask[n]) mem[idx_c][8*n +: 8] <= i_ribs_wdata[8*n +: 8];
      end
    end
  end

  assign o_ribs_gnt   = gnt_c;
  assign o_ribs_rsp   = rsp_q;
  assign o_ribs_rdata = rdata_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_rib_sram_slave.sv
// Bench for rib_sram_slave: one instance with no wait states driven through a
// scoreboard, one with three wait states checked cycle by cycle.
module tb_rib_sram_slave;

  logic        clk = 1'b0;
  logic        rstn;

  logic [31:0] addr0, wdata0, rdata0;
  logic        wr0, req0, rdy0, gnt0, rsp0, busy0;
  logic [3:0]  mask0;

  logic [31:0] addr3, wdata3, rdata3;
  logic        wr3, req3, rdy3, gnt3, rsp3, busy3;
  logic [3:0]  mask3;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[int];

  always #5 clk = ~clk;

  rib_sram_slave #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_ribs_addr(addr0), .i_ribs_wrcs(wr0),
    .i_ribs_mask(mask0), .i_ribs_wdata(wdata0), .i_ribs_req(req0),
    .o_ribs_gnt(gnt0), .o_ribs_rsp(rsp0), .o_ribs_rdata(rdata0),
    .i_ribs_rdy(rdy0), .o_busy(busy0)
  );

  rib_sram_slave #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_ribs_addr(addr3), .i_ribs_wrcs(wr3),
    .i_ribs_mask(mask3), .i_ribs_wdata(wdata3), .i_ribs_req(req3),
    .o_ribs_gnt(gnt3), .o_ribs_rsp(rsp3), .o_ribs_rdata(rdata3),
    .i_ribs_rdy(rdy3), .o_busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for dut0: retire the oldest response, then enqueue a new handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      chk("rst_rsp0", 32'(rsp0), 32'd0);
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_rdata0", rdata0, 32'h0);
    end else begin
      chk("rsp0", 32'(rsp0), 32'(exp_q.size() > 0));
      chk("busy0", 32'(busy0), 32'(exp_q.size() > 0));
      chk("gnt0", 32'(gnt0), 32'((exp_q.size() == 0) || rdy0));
      if (exp_q.size() > 0) begin
        if (rdy0) chk("rdata0_done", rdata0, exp_q.pop_front());
        else      chk("rdata0_stall", rdata0, exp_q[0]);
      end
      if (req0 && gnt0) begin
        int k;
        logic [31:0] w;
        k = int'(addr0[11:2]);
        if (wr0) begin
          w = model.exists(k) ? model[k] : 32'h0;
          for (int n = 0; n < 4; n++)
            if (mask0[n]) w[8*n +: 8] = wdata0[8*n +: 8];
          model[k] = w;
          exp_q.push_back(32'h0);
        end else begin
          exp_q.push_back(model.exists(k) ? model[k] : 32'h0);
        end
      end
    end
  end

  task automatic set0(input logic w, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    wr0 = w; addr0 = a; mask0 = m; wdata0 = d; req0 = 1'b1;
  endtask

  // Wait for the grant of the request on dut0; returns just after the handshake edge.
  task automatic wait_gnt0(output int waited);
    waited = 0;
    @(negedge clk);
    while (!gnt0 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!gnt0) chk("timeout_gnt0", 32'(gnt0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue0(input logic w, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, output int waited);
    set0(w, a, m, d);
    wait_gnt0(waited);
  endtask

  task automatic issue3(input logic w, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    int waited;
    wr3 = w; addr3 = a; mask3 = m; wdata3 = d; req3 = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!gnt3 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!gnt3) chk("timeout_gnt3", 32'(gnt3), 32'd1);
    @(posedge clk);
    #1;
    req3 = 1'b0;
  endtask

  // Walk dut3 through WAIT and into RESP after a handshake, checking each cycle.
  task automatic wait3_resp(input string tag, input logic [31:0] exp_rdata);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, "_wait_rsp"}, 32'(rsp3), 32'd0);
      chk({tag, "_wait_gnt"}, 32'(gnt3), 32'd0);
      chk({tag, "_wait_busy"}, 32'(busy3), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_rsp"}, 32'(rsp3), 32'd1);
    chk({tag, "_rdata"}, rdata3, exp_rdata);
    @(negedge clk);
    chk({tag, "_idle_rsp"}, 32'(rsp3), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy3), 32'd0);
  endtask

  initial begin
    int w;
    rstn = 1'b0;
    req0 = 0; wr0 = 0; addr0 = 0; mask0 = 0; wdata0 = 0; rdy0 = 1'b1;
    req3 = 0; wr3 = 0; addr3 = 0; mask3 = 0; wdata3 = 0; rdy3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp3", 32'(rsp3), 32'd0);
    chk("rst_gnt3", 32'(gnt3), 32'd0);
    chk("rst_rdata3", rdata3, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_gnt3", 32'(gnt3), 32'd1);
    chk("idle_busy3", 32'(busy3), 32'd0);
    @(posedge clk); #1;

    // Basic write then read.
    issue0(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w); req0 = 0;
    issue0(1'b0, 32'h10, 4'hF, 32'h0, w);        req0 = 0;
    repeat (2) @(posedge clk); #1;

    // Byte mask and empty mask.
    issue0(1'b1, 32'h20, 4'hF, 32'h11223344, w); req0 = 0;
    issue0(1'b1, 32'h20, 4'b0100, 32'h00AA0000, w); req0 = 0;
    issue0(1'b0, 32'h20, 4'h0, 32'h0, w); req0 = 0;
    issue0(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, w); req0 = 0;
    issue0(1'b0, 32'h20, 4'h0, 32'h0, w); req0 = 0;
    repeat (2) @(posedge clk); #1;

    // Back-to-back: grant must be open every cycle.
    for (int i = 0; i < 4; i++) begin
      issue0(1'b1, 32'(i * 4), 4'hF, 32'hA5000000 + 32'(i * 32'h01010101), w);
      chk("b2b_wr_gnt", 32'(w), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      issue0(1'b0, 32'(i * 4), 4'hF, 32'h0, w);
      chk("b2b_rd_gnt", 32'(w), 32'd0);
    end
    issue0(1'b1, 32'h14, 4'hF, 32'h55667788, w);
    issue0(1'b0, 32'h14, 4'hF, 32'h0, w);
    chk("wr_rd_gnt", 32'(w), 32'd0);
    req0 = 0;
    repeat (2) @(posedge clk); #1;

    // Backpressure with a pending request.
    rdy0 = 1'b0;
    issue0(1'b0, 32'h4, 4'hF, 32'h0, w);
    set0(1'b0, 32'h8, 4'hF, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rdy0 = 1'b1;
    wait_gnt0(w);
    chk("bp_gnt_on_rdy", 32'(w), 32'd0);
    req0 = 0;
    // Alias of word 4 (0x10) one memory-size up.
    issue0(1'b0, 32'h10 + 32'd4096, 4'hF, 32'h0, w); req0 = 0;
    repeat (2) @(posedge clk); #1;

    // Three wait states.
    issue3(1'b1, 32'h40, 4'hF, 32'h12345678);
    wait3_resp("w3_wr", 32'h0);
    issue3(1'b0, 32'h40, 4'hF, 32'h0);
    wait3_resp("w3_rd", 32'h12345678);

    // Reset in the middle of WAIT.
    @(posedge clk); #1;
    issue3(1'b1, 32'h80, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    chk("mid_busy3", 32'(busy3), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_rsp3", 32'(rsp3), 32'd0);
    chk("mid_rst_gnt3", 32'(gnt3), 32'd0);
    chk("mid_rst_busy3", 32'(busy3), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_rsp3", 32'(rsp3), 32'd0);
      chk("post_rst_gnt3", 32'(gnt3), 32'd1);
    end
    @(posedge clk); #1;
    issue3(1'b0, 32'h80 + 32'd4096, 4'hF, 32'h0);
    wait3_resp("alias3", 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rib_sram_slave.md
# rib_sram_slave

RIB bus responder wrapping a word-addressed, byte-maskable register memory. Sits on the slave side of the RIB interconnect, facing initiators such as the core load/store unit. Accepts one request per handshake and returns a response after a programmable number of wait states. Pipelined back-to-back transfers are supported when the initiator is ready.

## Interface
Parameters:
- DEPTH, 1024: memory size in 32-bit words; must be a power of two.
- AW, 10: word-index width, equal to log2(DEPTH).
- WAIT_CYCLES, 0: extra cycles inserted between handshake and response (0..15).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_ribs_addr  in  32  byte address; bits [AW+1:2] select the word; bits [1:0] and [31:AW+2] are ignored (aliasing).
- i_ribs_wrcs  in  1  1 = write, 0 = read.
- i_ribs_mask  in  4  byte-lane write enables; bit n covers wdata[8n+7:8n].
- i_ribs_wdata  in  32  write data, already lane-aligned by the initiator.
- i_ribs_req  in  1  request valid.
- o_ribs_gnt  out  1  grant; handshake = i_ribs_req & o_ribs_gnt.
- o_ribs_rsp  out  1  response valid.
- o_ribs_rdata  out  32  read data; valid while o_ribs_rsp is high.
- i_ribs_rdy  in  1  initiator accepts the response; the response completes when o_ribs_rsp & i_ribs_rdy.
- o_busy  out  1  high in WAIT or RESP.

## Operation
- The FSM has three states: IDLE, WAIT, RESP. Reset enters IDLE.
- o_ribs_gnt is combinational:
  - high in IDLE;
  - high in RESP when i_ribs_rdy is high;
  - low in WAIT;
  - forced low while i_rstn is low.
- Handshake, at the clock edge where req & gnt:
  - Write: for each set mask bit n, mem[idx][8n+7:8n] <= wdata[8n+7:8n]. With mask 0 the memory is unchanged, but the transfer still completes with a response.
  - Read: rdata_reg <= mem[idx], sampled at that edge.
  - Write response data: rdata_reg <= 0.
  - Wait counter: cnt <= WAIT_CYCLES.
  - Next state: WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: cnt decrements each cycle. When cnt == 1, go to RESP.
- RESP: o_ribs_rsp = 1 and o_ribs_rdata = rdata_reg.
  - i_ribs_rdy = 0: hold RESP; rsp and rdata stay stable.
  - i_ribs_rdy = 1 and no new req: go to IDLE.
  - i_ribs_rdy = 1 and req (granted in the same cycle): the new handshake is taken and the state moves to WAIT or RESP as above. rsp stays high across the boundary with the new data.
- Memory contents are not initialised and are not cleared by reset.
- Ordering: a write commits at its handshake edge, so a read handshaked in the next cycle returns the new data.

## Timing
- Reset values: o_ribs_rsp = 0, o_ribs_rdata = 0, o_ribs_gnt = 0 during reset and 1 after release (IDLE), o_busy = 0, cnt = 0.
- Latency: handshake at cycle N gives o_ribs_rsp high at cycle N+1+WAIT_CYCLES.
- Throughput:
  - WAIT_CYCLES = 0 with i_ribs_rdy held high: 1 transfer per cycle.
  - Otherwise: 1 transfer per WAIT_CYCLES+1 cycles.
- o_ribs_rdata changes only at a handshake edge; it is never modified while the response is stalled.
- Reset asserted mid-transfer: the state returns to IDLE immediately and the pending response is dropped. A write already committed at its handshake edge remains in memory.
- req held with gnt low (WAIT, or RESP with rdy = 0): no state effect; the request is taken later when gnt rises.

## Test plan
- Reset, WAIT_CYCLES = 0: write addr 0x10, mask 4'b1111, data 0xDEADBEEF; read 0x10 -> rsp one cycle after each handshake; read data 0xDEADBEEF; write response rdata = 0.
- Byte mask: preload word 0x11223344; write mask 4'b0100 with data 0x00AA0000; read -> 0x11AA3344. Write with mask 0 -> word unchanged, rsp still asserted.
- Back-to-back: WAIT_CYCLES = 0, rdy = 1, four reads to words 0..3 on consecutive cycles -> gnt high every cycle; rsp high for 4 consecutive cycles with matching data; write to word 5 followed next cycle by a read of word 5 returns the new value.
- Backpressure: rdy = 0 for 3 cycles during RESP -> rsp and rdata stable, gnt low; a pending req is granted in the cycle rdy rises.
- WAIT_CYCLES = 3: handshake at cycle N -> rsp at N+4; gnt low and o_busy high during cycles N+1..N+3.
- Reset mid-WAIT: i_rstn pulsed low after a write handshake -> rsp = 0 and IDLE; a subsequent read returns the written data; the address aliasing check (addr + DEPTH*4) hits the same word.
